// File: rtl/mul_div_pkg.sv
// rtl/mul_div_pkg.sv - shared encodings and constants for the HI/LO multiply/divide unit
// Purpose: op encodings, FSM state enum, iteration count, divide-by-zero LO value,
//          and the absolute-value helper used when latching signed operands.
package mul_div_pkg;

   localparam int          ITER    = 32;
   localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } md_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } md_state_e;

   // 0x80000000 maps to itself, which is exactly the wrap the signed
   // overflow case relies on.
   function automatic logic [31:0] abs32(input logic [31:0] v);
      return v[31] ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/md_sign_fix.sv
// rtl/md_sign_fix.sv - sign correction and divide-by-zero handling for raw results
// Purpose: turns the unsigned accumulator result into the final HI/LO pair.
// Ports:
//   op          in   latched operation
//   mag_a/mag_b in   latched operand magnitudes
//   sign_a/b    in   latched operand sign flags (always 0 for unsigned ops)
//   acc         in   raw accumulator: product, or {remainder, quotient}
//   res_hi/lo   out  corrected HI/LO result
module md_sign_fix
   import mul_div_pkg::*;
(
   input  md_op_e      op,
   input  logic [31:0] mag_a,
   input  logic [31:0] mag_b,
   input  logic        sign_a,
   input  logic        sign_b,
   input  logic [63:0] acc,
   output logic [31:0] res_hi,
   output logic [31:0] res_lo
);

   logic        is_div;
   logic        signs_differ;
   logic [31:0] raw_a;
   logic [63:0] product;
   logic [31:0] quot_fix;
   logic [31:0] rem_fix;

   always_comb begin
      is_div       = (op == OP_DIV) || (op == OP_DIVU);
      signs_differ = sign_a ^ sign_b;
      // Rebuilding the original dividend from magnitude and sign avoids
      // holding a separate copy of a for the divide-by-zero result.
      raw_a    = sign_a ? (~mag_a + 32'd1) : mag_a;
      product  = signs_differ ? (~acc + 64'd1) : acc;
      quot_fix = signs_differ ? (~acc[31:0] + 32'd1) : acc[31:0];
      rem_fix  = sign_a ? (~acc[63:32] + 32'd1) : acc[63:32];

      res_hi = product[63:32];
      res_lo = product[31:0];
      if (is_div) begin
         if (mag_b == 32'd0) begin
            res_hi = raw_a;
            res_lo = DIV0_LO;
         end else begin
            res_hi = rem_fix;
            res_lo = quot_fix;
         end
      end
   end

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit producing next HI/LO values
// Purpose: one-bit-per-cycle shift-add multiply and restoring divide, plus the
//          zero-latency MTHI/MTLO path. write_hi/write_lo mirror cur_hi/cur_lo
//          unless a result or a move is being committed.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, op, a, b     launch request (sampled in IDLE only)
//   mthi, mtlo, mt_data register moves (IDLE only)
//   cur_hi, cur_lo      current HI/LO contents
//   busy, done          in-progress flag, one-cycle result strobe
//   write_hi, write_lo  next HI/LO values
module mul_div_unit
   import mul_div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] mt_data,
   input  logic [WIDTH-1:0] cur_hi,
   input  logic [WIDTH-1:0] cur_lo,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] write_hi,
   output logic [WIDTH-1:0] write_lo
);

   localparam int CW = $clog2(ITER);

   md_state_e          state_q, state_d;
   md_op_e             op_q, op_d;
   logic [WIDTH-1:0]   mag_a_q, mag_a_d;
   logic [WIDTH-1:0]   mag_b_q, mag_b_d;
   logic               sign_a_q, sign_a_d;
   logic               sign_b_q, sign_b_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]      count_q, count_d;

   md_op_e             op_in;
   logic               in_signed;
   logic [CW-1:0]      bit_idx;
   logic [2*WIDTH-1:0] mul_step;
   logic [WIDTH:0]     div_trial;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] div_step;
   logic [WIDTH-1:0]   res_hi;
   logic [WIDTH-1:0]   res_lo;

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      mag_a_d  = mag_a_q;
      mag_b_d  = mag_b_q;
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
      acc_d    = acc_q;
      count_d  = count_q;

      op_in     = md_op_e'(op);
      in_signed = (op_in == OP_MULT) || (op_in == OP_DIV);

      // Both datapaths walk the operand bits MSB first.
      bit_idx = CW'(ITER - 1) - count_q;

      // Multiply: product = (product << 1) + (b bit ? a : 0).
      mul_step = {acc_q[2*WIDTH-2:0], 1'b0}
               + (mag_b_q[bit_idx] ? {{WIDTH{1'b0}}, mag_a_q} : {(2*WIDTH){1'b0}});

      // Divide: acc holds {remainder, quotient}; shift the next dividend bit
      // into the remainder and subtract the divisor if it fits.
      div_trial = {acc_q[2*WIDTH-1:WIDTH], mag_a_q[bit_idx]};
      div_diff  = div_trial - {1'b0, mag_b_q};
      if (!div_diff[WIDTH])
         div_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else
         div_step = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = RUN;
               op_d     = op_in;
               mag_a_d  = in_signed ? abs32(a) : a;
               mag_b_d  = in_signed ? abs32(b) : b;
               sign_a_d = in_signed & a[WIDTH-1];
               sign_b_d = in_signed & b[WIDTH-1];
               acc_d    = '0;
               count_d  = '0;
            end
         end
         RUN: begin
            acc_d   = (op_q == OP_DIV || op_q == OP_DIVU) ? div_step : mul_step;
            count_d = count_q + 1'b1;
            if (count_q == CW'(ITER - 1))
               state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         op_q     <= OP_MULT;
         mag_a_q  <= '0;
         mag_b_q  <= '0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         acc_q    <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         mag_a_q  <= mag_a_d;
         mag_b_q  <= mag_b_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         acc_q    <= acc_d;
         count_q  <= count_d;
      end
   end

   md_sign_fix u_sign_fix (
      .op     (op_q),
      .mag_a  (mag_a_q),
      .mag_b  (mag_b_q),
      .sign_a (sign_a_q),
      .sign_b (sign_b_q),
      .acc    (acc_q),
      .res_hi (res_hi),
      .res_lo (res_lo)
   );

   // HI/LO reload every cycle, so the default is to hand back the current
   // contents; only a result or an IDLE move changes them.
   always_comb begin
      busy     = (state_q == RUN) || (state_q == DONE);
      done     = (state_q == DONE);
      write_hi = cur_hi;
      write_lo = cur_lo;
      if (state_q == DONE) begin
         write_hi = res_hi;
         write_lo = res_lo;
      end else if (state_q == IDLE) begin
         if (mthi) write_hi = mt_data;
         if (mtlo) write_lo = mt_data;
      end
   end

endmodule
